// File: rtl/hazard_if.sv
// Pipeline <-> hazard unit signal bundle: ID/EX hazard sources in, stall/flush controls and counters out.
interface hazard_if;
  logic [4:0]  ID_Rs_addr;
  logic [4:0]  ID_Rt_addr;
  logic        ID_Uses_Rt;
  logic        ID_EX_MemRead;
  logic [4:0]  ID_EX_Rt_addr;
  logic        EX_Branch_taken;
  logic        EX_MulDiv;
  logic        PC_Write;
  logic        IF_ID_Write;
  logic        ID_EX_Write;
  logic        IF_ID_Flush;
  logic        ID_EX_Flush;
  logic        EX_MEM_Flush;
  logic        MD_Busy;
  logic [15:0] Stall_count;
  logic [15:0] Flush_count;

  modport master (
    output ID_Rs_addr, ID_Rt_addr, ID_Uses_Rt, ID_EX_MemRead, ID_EX_Rt_addr,
           EX_Branch_taken, EX_MulDiv,
    input  PC_Write, IF_ID_Write, ID_EX_Write, IF_ID_Flush, ID_EX_Flush,
           EX_MEM_Flush, MD_Busy, Stall_count, Flush_count
  );

  modport slave (
    input  ID_Rs_addr, ID_Rt_addr, ID_Uses_Rt, ID_EX_MemRead, ID_EX_Rt_addr,
           EX_Branch_taken, EX_MulDiv,
    output PC_Write, IF_ID_Write, ID_EX_Write, IF_ID_Flush, ID_EX_Flush,
           EX_MEM_Flush, MD_Busy, Stall_count, Flush_count
  );
endinterface

// File: rtl/hazard_unit.sv
// Hazard unit: mult/div occupancy stall, taken-branch flush and load-use stall, plus
// saturating stall/flush performance counters.
module hazard_unit #(
  parameter int MD_LATENCY = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  hazard_if.slave  hz
);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY - 2);

  state_t      state_q, state_d;
  logic [3:0]  md_cnt_q, md_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic        md_stall_s;
  logic        load_use_s;
  logic        branch_flush_s;
  logic        pc_write_s, if_id_write_s, id_ex_write_s;
  logic        if_id_flush_s, id_ex_flush_s, ex_mem_flush_s;

  // State, occupancy counter and performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      md_cnt_q    <= 4'd0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Mult/div sequencing; the final MD_BUSY cycle is stall-free and cannot retrigger.
  always_comb begin
    state_d    = state_q;
    md_cnt_d   = md_cnt_q;
    md_stall_s = 1'b0;
    case (state_q)
      RUN: begin
        if (hz.EX_MulDiv) begin
          md_stall_s = 1'b1;
          md_cnt_d   = MD_LOAD;
          state_d    = MD_BUSY;
        end else begin
          state_d = RUN;
        end
      end
      MD_BUSY: begin
        if (md_cnt_q != 4'd0) begin
          md_stall_s = 1'b1;
          md_cnt_d   = md_cnt_q - 4'd1;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d  = RUN;
        md_cnt_d = 4'd0;
      end
    endcase
  end

  // Register 0 is excluded through the load destination check.
  assign load_use_s = hz.ID_EX_MemRead && (hz.ID_EX_Rt_addr != 5'd0) &&
                      ((hz.ID_EX_Rt_addr == hz.ID_Rs_addr) ||
                       (hz.ID_Uses_Rt && (hz.ID_EX_Rt_addr == hz.ID_Rt_addr)));

  // Control priority: mult/div stall, then branch flush, then load-use; reset forces defaults.
  always_comb begin
    pc_write_s     = 1'b1;
    if_id_write_s  = 1'b1;
    id_ex_write_s  = 1'b1;
    if_id_flush_s  = 1'b0;
    id_ex_flush_s  = 1'b0;
    ex_mem_flush_s = 1'b0;
    branch_flush_s = 1'b0;
    if (rst_n && md_stall_s) begin
      pc_write_s     = 1'b0;
      if_id_write_s  = 1'b0;
      id_ex_write_s  = 1'b0;
      ex_mem_flush_s = 1'b1;
    end else if (rst_n && hz.EX_Branch_taken) begin
      branch_flush_s = 1'b1;
      if_id_flush_s  = 1'b1;
      id_ex_flush_s  = 1'b1;
    end else if (rst_n && load_use_s) begin
      pc_write_s    = 1'b0;
      if_id_write_s = 1'b0;
      id_ex_flush_s = 1'b1;
    end else begin
      pc_write_s = 1'b1;
    end
  end

  // Saturating performance counter next-state.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write_s && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (branch_flush_s && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  assign hz.PC_Write     = pc_write_s;
  assign hz.IF_ID_Write  = if_id_write_s;
  assign hz.ID_EX_Write  = id_ex_write_s;
  assign hz.IF_ID_Flush  = if_id_flush_s;
  assign hz.ID_EX_Flush  = id_ex_flush_s;
  assign hz.EX_MEM_Flush = ex_mem_flush_s;
  assign hz.MD_Busy      = rst_n && md_stall_s;
  assign hz.Stall_count  = stall_cnt_q;
  assign hz.Flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: an occupancy-based reference model predicts every cycle's
// controls and counters; a negedge monitor pops and compares them.
module tb_hazard_unit;
  localparam int LAT = 4;

  typedef struct packed {
    logic        pc_w;
    logic        ifid_w;
    logic        idex_w;
    logic        ifid_f;
    logic        idex_f;
    logic        exmem_f;
    logic        busy;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  hazard_if hz ();

  hazard_unit #(.MD_LATENCY(LAT)) dut (.clk(clk), .rst_n(rst_n), .hz(hz));

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // Reference model state: remaining EX occupancy of the current mult/div, and event totals.
  int   occ     = 0;
  int   n_stall = 0;
  int   n_flush = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive(input bit rst, input logic [4:0] rs, input logic [4:0] rt,
                       input bit uses, input bit mr, input logic [4:0] ldrt,
                       input bit br, input bit md);
    exp_t e;
    bit   lu;
    bit   md_stall;
    @(posedge clk);
    #1;
    rst_n              = rst;
    hz.ID_Rs_addr      = rs;
    hz.ID_Rt_addr      = rt;
    hz.ID_Uses_Rt      = uses;
    hz.ID_EX_MemRead   = mr;
    hz.ID_EX_Rt_addr   = ldrt;
    hz.EX_Branch_taken = br;
    hz.EX_MulDiv       = md;
    if (!rst) begin
      occ     = 0;
      n_stall = 0;
      n_flush = 0;
    end
    e = '{pc_w: 1'b1, ifid_w: 1'b1, idex_w: 1'b1, ifid_f: 1'b0, idex_f: 1'b0,
          exmem_f: 1'b0, busy: 1'b0, stall_cnt: 16'(n_stall), flush_cnt: 16'(n_flush)};
    if (rst) begin
      // A mult/div occupies EX for LAT cycles; all but the last one stall the front end.
      if (occ == 0 && md) occ = LAT;
      md_stall = (occ > 1);
      lu = mr && (ldrt != 5'd0) && (ldrt == rs || (uses && ldrt == rt));
      if (md_stall) begin
        e.pc_w = 1'b0; e.ifid_w = 1'b0; e.idex_w = 1'b0; e.exmem_f = 1'b1; e.busy = 1'b1;
      end else if (br) begin
        e.ifid_f = 1'b1; e.idex_f = 1'b1;
      end else if (lu) begin
        e.pc_w = 1'b0; e.ifid_w = 1'b0; e.idex_f = 1'b1;
      end
      if (!e.pc_w && n_stall < 65535) n_stall++;
      if (!md_stall && br && n_flush < 65535) n_flush++;
      if (occ > 0) occ--;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // Monitor: compare every presented cycle of DUT outputs against the oldest prediction.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      exp_t a;
      e = exp_q.pop_front();
      a = '{pc_w: hz.PC_Write, ifid_w: hz.IF_ID_Write, idex_w: hz.ID_EX_Write,
            ifid_f: hz.IF_ID_Flush, idex_f: hz.ID_EX_Flush, exmem_f: hz.EX_MEM_Flush,
            busy: hz.MD_Busy, stall_cnt: hz.Stall_count, flush_cnt: hz.Flush_count};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL outputs cycle %0d: actual pc/ifw/idw/iff/idf/exf/busy=%b%b%b%b%b%b%b stall=%0d flush=%0d, required %b%b%b%b%b%b%b stall=%0d flush=%0d",
                 cyc, a.pc_w, a.ifid_w, a.idex_w, a.ifid_f, a.idex_f, a.exmem_f, a.busy,
                 a.stall_cnt, a.flush_cnt, e.pc_w, e.ifid_w, e.idex_w, e.ifid_f, e.idex_f,
                 e.exmem_f, e.busy, e.stall_cnt, e.flush_cnt);
      end
      cyc++;
    end
  end

  initial begin
    int wait_cycles;
    rst_n = 1'b0;
    hz.ID_Rs_addr = 5'd0; hz.ID_Rt_addr = 5'd0; hz.ID_Uses_Rt = 1'b0;
    hz.ID_EX_MemRead = 1'b0; hz.ID_EX_Rt_addr = 5'd0;
    hz.EX_Branch_taken = 1'b0; hz.EX_MulDiv = 1'b0;

    // Reset with hazard-looking inputs present: outputs must stay at defaults.
    drive(1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    idle(1);

    // Load-use on Rs, then counter shows one stall.
    drive(1'b1, 5'd5, 5'd1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
    idle(1);
    // Register 0 never hazards; Rt ignored unless used; Rt used does hazard.
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    drive(1'b1, 5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
    drive(1'b1, 5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
    idle(1);

    // Mult/div held for 4 cycles, then a back-to-back pair.
    for (int i = 0; i < 4; i++) drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    idle(1);
    for (int i = 0; i < 8; i++) drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    idle(1);

    // Branch wins over load-use.
    drive(1'b1, 5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0);
    idle(1);

    // Reset during the second busy cycle, then a fresh full stall.
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    idle(1);

    // Randomized mix over a small register range so hazards are frequent.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) != 0),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 1),
            5'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 6) == 0));
    end

    // Saturation: continuous load-use stalls beyond 65535 cycles.
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 65540; i++) drive(1'b1, 5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0);
    idle(3);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      fails++;
      $display("FAIL drain_timeout: actual %0d pending, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
